// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator (hs/vs/de, pixel
// coordinates, frame/line strobes) driven from a single pixel clock.
//
// Ports:
//   clk          pixel clock
//   rst          synchronous active-high reset
//   en           run request, sampled every cycle
//   hs, vs       sync outputs, asserted level HS_POL / VS_POL
//   de           data enable, high on active pixels
//   active_x/y   pixel column/row while de, else 0
//   frame_start  1-cycle pulse at h=0, v=0
//   line_start   1-cycle pulse at h=0 of every line
//   running      high while a frame is being generated
//   rgb          colour-bar pixel {R,G,B}
//
// Optional feature: define VTG_PATTERN_EN to build the colour-bar
// generator on rgb. Without it rgb is tied to zero.
//
// Counter order within a line (and lines within a frame):
//   sync, back porch, active, front porch.
// All outputs are registered one cycle after the counter position.

module video_timing_gen #(
   parameter int   CW       = 12,
   parameter int   H_ACTIVE = 800,
   parameter int   H_FP     = 210,
   parameter int   H_SYNC   = 1,
   parameter int   H_BP     = 182,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 45,
   parameter int   V_SYNC   = 1,
   parameter int   V_BP     = 8,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic          hs,
   output logic          vs,
   output logic          de,
   output logic [CW-1:0] active_x,
   output logic [CW-1:0] active_y,
   output logic          frame_start,
   output logic          line_start,
   output logic          running,
   output logic [23:0]   rgb
);

   localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int HA_START = H_SYNC + H_BP;
   localparam int HA_END   = HA_START + H_ACTIVE;
   localparam int VA_START = V_SYNC + V_BP;
   localparam int VA_END   = VA_START + V_ACTIVE;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_SW   = CW'(H_SYNC);
   localparam logic [CW-1:0] V_SW   = CW'(V_SYNC);
   localparam logic [CW-1:0] H_AS   = CW'(HA_START);
   localparam logic [CW-1:0] H_AE   = CW'(HA_END);
   localparam logic [CW-1:0] V_AS   = CW'(VA_START);
   localparam logic [CW-1:0] V_AE   = CW'(VA_END);

   // Reject timings the counters cannot represent or that make no sense.
   if (H_TOTAL > (2 ** CW) - 1 || V_TOTAL > (2 ** CW) - 1 ||
       H_ACTIVE == 0 || V_ACTIVE == 0 ||
       H_SYNC == 0 || V_SYNC == 0) begin : g_bad_cfg
      $error("video_timing_gen: illegal timing parameters");
   end

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state;
   logic [CW-1:0] h_cnt;
   logic [CW-1:0] v_cnt;

   logic run;
   logic h_vis;
   logic v_vis;
   logic de_d;

   always_comb begin
      run   = (state == RUN);
      h_vis = (h_cnt >= H_AS) && (h_cnt < H_AE);
      v_vis = (v_cnt >= V_AS) && (v_cnt < V_AE);
      de_d  = run && h_vis && v_vis;
   end

   // State, counters and registered timing outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         h_cnt       <= '0;
         v_cnt       <= '0;
         hs          <= ~HS_POL;
         vs          <= ~VS_POL;
         de          <= 1'b0;
         active_x    <= '0;
         active_y    <= '0;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
         running     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               h_cnt <= '0;
               v_cnt <= '0;
               if (en) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (h_cnt == H_LAST) begin
                  h_cnt <= '0;
                  if (v_cnt == V_LAST) begin
                     v_cnt <= '0;
                     // Stopping is only possible on a frame boundary.
                     if (!en) begin
                        state <= IDLE;
                     end
                  end else begin
                     v_cnt <= v_cnt + 1'b1;
                  end
               end else begin
                  h_cnt <= h_cnt + 1'b1;
               end
            end
         endcase

         if (run) begin
            hs          <= (h_cnt < H_SW) ? HS_POL : ~HS_POL;
            vs          <= (v_cnt < V_SW) ? VS_POL : ~VS_POL;
            de          <= de_d;
            active_x    <= de_d ? (h_cnt - H_AS) : '0;
            active_y    <= de_d ? (v_cnt - V_AS) : '0;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            line_start  <= (h_cnt == '0);
            running     <= 1'b1;
         end else begin
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b0;
            active_x    <= '0;
            active_y    <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            running     <= 1'b0;
         end
      end
   end

`ifdef VTG_PATTERN_EN

   localparam int BAR_W = H_ACTIVE / 8;
   localparam logic [CW-1:0] BW_LAST =
      CW'((BAR_W == 0) ? 0 : BAR_W - 1);
   // With fewer than 8 active pixels every pixel is remainder: black.
   localparam logic [2:0] IDX_FIRST =
      (BAR_W == 0) ? 3'd7 : 3'd0;

   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      logic [23:0] c;
      c = 24'h000000;
      unique case (idx)
         3'd0: c = 24'hFFFFFF;
         3'd1: c = 24'hFFFF00;
         3'd2: c = 24'h00FFFF;
         3'd3: c = 24'h00FF00;
         3'd4: c = 24'hFF00FF;
         3'd5: c = 24'hFF0000;
         3'd6: c = 24'h0000FF;
         3'd7: c = 24'h000000;
      endcase
      return c;
   endfunction

   logic [CW-1:0] bar_px;
   logic [2:0]    bar_idx;
   logic [CW-1:0] cur_px;
   logic [2:0]    cur_idx;
   logic [23:0]   rgb_q;

   // The first active pixel of each line restarts the bar sequence.
   always_comb begin
      cur_px  = bar_px;
      cur_idx = bar_idx;
      if (h_cnt == H_AS) begin
         cur_px  = '0;
         cur_idx = IDX_FIRST;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bar_px  <= '0;
         bar_idx <= '0;
         rgb_q   <= '0;
      end else begin
         if (de_d) begin
            if (cur_px == BW_LAST) begin
               bar_px  <= '0;
               // Saturate on black so remainder pixels stay black.
               bar_idx <= (cur_idx == 3'd7) ? cur_idx : cur_idx + 3'd1;
            end else begin
               bar_px  <= cur_px + 1'b1;
               bar_idx <= cur_idx;
            end
         end
         rgb_q <= de_d ? bar_colour(cur_idx) : 24'h0;
      end
   end

   assign rgb = rgb_q;

`else

   assign rgb = 24'h0;

`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed bench for video_timing_gen using a small
// raster (H 8/2/1/3, V 4/1/1/2) plus a 16-pixel-wide copy for colour bars.

module tb_video_timing_gen;

   localparam int CW = 6;
   localparam int HT = 14;
   localparam int HT_B = 22;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;

   logic          a_hs, a_vs, a_de, a_fs, a_ls, a_run;
   logic [CW-1:0] a_x, a_y;
   logic [23:0]   a_rgb;

   logic          b_hs, b_vs, b_de, b_fs, b_ls, b_run;
   logic [CW-1:0] b_x, b_y;
   logic [23:0]   b_rgb;

   int n_tests = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   video_timing_gen #(
      .CW(CW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(1), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) u_dut (
      .clk(clk), .rst(rst), .en(en),
      .hs(a_hs), .vs(a_vs), .de(a_de),
      .active_x(a_x), .active_y(a_y),
      .frame_start(a_fs), .line_start(a_ls),
      .running(a_run), .rgb(a_rgb)
   );

   video_timing_gen #(
      .CW(CW), .H_ACTIVE(16), .H_FP(2), .H_SYNC(1), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) u_dut_bar (
      .clk(clk), .rst(rst), .en(en),
      .hs(b_hs), .vs(b_vs), .de(b_de),
      .active_x(b_x), .active_y(b_y),
      .frame_start(b_fs), .line_start(b_ls),
      .running(b_run), .rgb(b_rgb)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] bar(input int idx);
      case (idx)
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   task automatic check_a_idle(input string t);
      check({t, " hs"}, 32'(a_hs), 32'd1);
      check({t, " vs"}, 32'(a_vs), 32'd1);
      check({t, " de"}, 32'(a_de), 32'd0);
      check({t, " x"}, 32'(a_x), 32'd0);
      check({t, " y"}, 32'(a_y), 32'd0);
      check({t, " fs"}, 32'(a_fs), 32'd0);
      check({t, " ls"}, 32'(a_ls), 32'd0);
      check({t, " run"}, 32'(a_run), 32'd0);
      check({t, " rgb"}, 32'(a_rgb), 32'd0);
   endtask

   task automatic check_b_idle(input string t);
      check({t, " b_hs"}, 32'(b_hs), 32'd1);
      check({t, " b_vs"}, 32'(b_vs), 32'd1);
      check({t, " b_de"}, 32'(b_de), 32'd0);
      check({t, " b_xy"}, 32'({b_x, b_y}), 32'd0);
      check({t, " b_str"}, 32'({b_fs, b_ls}), 32'd0);
      check({t, " b_run"}, 32'(b_run), 32'd0);
      check({t, " b_rgb"}, 32'(b_rgb), 32'd0);
   endtask

   // Expected outputs of the small raster at frame cycle n (0..111).
   task automatic check_a_pos(input int n);
      int h, v;
      bit d;
      string t;
      h = n % HT;
      v = n / HT;
      d = (h >= 4) && (h < 12) && (v >= 3) && (v < 7);
      t = $sformatf("h%0d v%0d", h, v);
      check({t, " hs"}, 32'(a_hs), (h < 1) ? 32'd0 : 32'd1);
      check({t, " vs"}, 32'(a_vs), (v < 1) ? 32'd0 : 32'd1);
      check({t, " de"}, 32'(a_de), 32'(d));
      check({t, " x"}, 32'(a_x), d ? 32'(h - 4) : 32'd0);
      check({t, " y"}, 32'(a_y), d ? 32'(v - 3) : 32'd0);
      check({t, " fs"}, 32'(a_fs), 32'(n == 0));
      check({t, " ls"}, 32'(a_ls), 32'(h == 0));
      check({t, " run"}, 32'(a_run), 32'd1);
   endtask

   initial begin
      int de_cnt;
      int hs_lo;
      int vs_lo;

      // 1. reset, start, frame period
      rst = 1'b1;
      en = 1'b0;
      repeat (3) step();
      check_a_idle("reset");
      check_b_idle("reset");
      rst = 1'b0;
      en = 1'b1;
      step();
      check("fs_early", 32'(a_fs), 32'd0);
      check("run_early", 32'(a_run), 32'd0);
      step();
      check("fs_start", 32'(a_fs), 32'd1);

      // 2./3. full frame: de runs, sync counts
      de_cnt = 0;
      hs_lo = 0;
      vs_lo = 0;
      for (int n = 0; n < 112; n++) begin
         check_a_pos(n);
         if (a_de) de_cnt++;
         if (!a_hs) hs_lo++;
         if (!a_vs) vs_lo++;
         step();
      end
      check("fs_period", 32'(a_fs), 32'd1);
      check("de_count", 32'(de_cnt), 32'd32);
      check("hs_low_count", 32'(hs_lo), 32'd8);
      check("vs_low_count", 32'(vs_lo), 32'd14);

      // 4. drop en mid-frame: frame completes, then idle
      for (int n = 0; n < 112; n++) begin
         check_a_pos(n);
         if (n == 32) en = 1'b0;
         step();
      end
      check_a_idle("stop");
      for (int i = 0; i < 20; i++) begin
         step();
         check("idle_fs", 32'(a_fs), 32'd0);
         check("idle_run", 32'(a_run), 32'd0);
         check("idle_sync", 32'({a_hs, a_vs}), 32'd3);
      end

      // 5. reset mid-frame at v=4, restart
      en = 1'b1;
      step();
      step();
      for (int n = 0; n < 56; n++) begin
         check_a_pos(n);
         step();
      end
      check("pre_rst_line", 32'(a_ls), 32'd1);
      rst = 1'b1;
      step();
      check_a_idle("rst_mid");
      check_b_idle("rst_mid");
      rst = 1'b0;
      step();
      check("restart_run0", 32'(a_run), 32'd0);
      step();
      check_a_pos(0);

      // 6. colour bars on the 16-pixel raster
      for (int m = 0; m < 176; m++) begin
         int h, v;
         bit d;
         logic [23:0] exp_rgb;
         h = m % HT_B;
         v = m / HT_B;
         d = (h >= 4) && (h < 20) && (v >= 3) && (v < 7);
`ifdef VTG_PATTERN_EN
         exp_rgb = d ? bar((h - 4) / 2) : 24'h0;
`else
         exp_rgb = 24'h0;
`endif
         check($sformatf("bar h%0d v%0d de", h, v), 32'(b_de), 32'(d));
         check($sformatf("bar h%0d v%0d rgb", h, v), 32'(b_rgb), 32'(exp_rgb));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
